// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states, the FIFO
// entry record and the PC increment.
package fetch_pkg;

  localparam int FETCH_DATA_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]             pc;
    logic [FETCH_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer (master) and the ROM/decode side
// (slave): ROM address/data, decode handshake, redirect and fault.
interface imem_fetch_ctrl_if #(
  parameter int AW     = 10,
  parameter int DATA_W = 32
);
  logic              fetch_en;
  logic [AW-1:0]     rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] inst_o;
  logic [31:0]       pc_o;
  logic              inst_valid;
  logic              inst_ready;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              fetch_fault;

  modport master (
    input  fetch_en, rom_data, inst_ready, redirect, redirect_pc,
    output rom_addr, inst_o, pc_o, inst_valid, fetch_fault
  );

  modport slave (
    output fetch_en, rom_data, inst_ready, redirect, redirect_pc,
    input  rom_addr, inst_o, pc_o, inst_valid, fetch_fault
  );
endinterface

// File: rtl/imem_fetch_ctrl_fifo.sv
// Synchronous FIFO of fetch entries; clear beats push/pop, full/empty come
// from the occupancy count rather than pointer equality.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t   mem_r [DEPTH];
  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic           pop_ok_s;
  logic           push_ok_s;

  assign empty     = (count_r == CW'(0));
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, ROM addressing, fetch FIFO and redirect.
// Optional out-of-range fault detection is enabled by FETCH_BOUND_CHECK_EN.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ROM_DEPTH  = 1024,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  imem_fetch_ctrl_if.master  bus
);
  localparam int AW = $clog2(ROM_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  fetch_state_t  state_r;
  fetch_state_t  state_n;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   target_pc_s;
  logic          redirect_s;
  logic          pop_s;
  logic          push_s;
  logic          room_s;
  logic          oob_s;
  fetch_entry_t  wr_entry_s;
  fetch_entry_t  head_s;
  logic [CW-1:0] count_s;
  logic          full_s;
  logic          empty_s;

  assign target_pc_s = bus.redirect_pc & 32'hFFFF_FFFC;
  assign redirect_s  = bus.redirect && (state_r != FAULT);
  assign pop_s       = !empty_s && bus.inst_ready;
  assign room_s      = (count_s < CW'(FIFO_DEPTH)) || (full_s && pop_s);
  assign wr_entry_s  = '{pc: fetch_pc_r, inst: bus.rom_data};

`ifdef FETCH_BOUND_CHECK_EN
  logic fault_r;
  assign oob_s           = |fetch_pc_r[31:AW+2];
  assign bus.fetch_fault = fault_r;
`else
  assign oob_s           = 1'b0;
  assign bus.fetch_fault = 1'b0;
`endif

  // A push needs RUN, fetch enabled, room, an in-range PC and no redirect.
  assign push_s = (state_r == RUN) && bus.fetch_en && room_s && !oob_s && !redirect_s;

  assign bus.rom_addr   = fetch_pc_r[AW+1:2];
  assign bus.inst_valid = !empty_s;
  assign bus.pc_o       = head_s.pc;
  assign bus.inst_o     = head_s.inst;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .clear (redirect_s),
    .din   (wr_entry_s),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // FSM next-state decode.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (bus.fetch_en) state_n = RUN;
        else              state_n = IDLE;
      end
      RUN: begin
        if (!bus.fetch_en)             state_n = IDLE;
        else if (oob_s && !redirect_s) state_n = FAULT;
        else                           state_n = RUN;
      end
      FAULT: begin
`ifdef FETCH_BOUND_CHECK_EN
        state_n = FAULT;
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; FAULT is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_n;
  end

  // Fetch PC: redirect beats the sequential increment.
  always_ff @(posedge clk) begin
    if (rst)             fetch_pc_r <= RESET_PC;
    else if (redirect_s) fetch_pc_r <= target_pc_s;
    else if (push_s)     fetch_pc_r <= fetch_pc_r + PC_STEP;
    else                 fetch_pc_r <= fetch_pc_r;
  end

`ifdef FETCH_BOUND_CHECK_EN
  // Registered fault flag, high from the cycle after FAULT is entered.
  always_ff @(posedge clk) begin
    if (rst) fault_r <= 1'b0;
    else     fault_r <= (state_n == FAULT);
  end
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed table-driven bench for imem_fetch_ctrl; expectations follow the
// FETCH_BOUND_CHECK_EN setting of the build.
module tb_imem_fetch_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl_if #(.AW(10), .DATA_W(32)) bus ();

  imem_fetch_ctrl #(
    .ROM_DEPTH (1024),
    .DATA_W    (32),
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM model: word k holds A000_0000 + k.
  assign bus.rom_data = 32'hA000_0000 + {22'd0, bus.rom_addr};

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [9:0]  addr;
    logic        fault;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(logic fe, logic rdy, logic redir, logic [31:0] rpc,
                              logic valid, logic [31:0] pc, logic [31:0] inst,
                              logic [9:0] addr, logic fault);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.valid = valid; v.pc = pc; v.inst = inst; v.addr = addr; v.fault = fault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fe, input logic rdy, input logic redir, input logic [31:0] rpc);
    bus.fetch_en    = fe;
    bus.inst_ready  = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   32'h0,         10'h000, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,   32'hA000_0000, 10'h001, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4,   32'hA000_0001, 10'h002, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8,   32'hA000_0002, 10'h003, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8,   32'hA000_0002, 10'h004, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8,   32'hA000_0002, 10'h004, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8,   32'hA000_0002, 10'h004, 1'b0);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8,   32'hA000_0002, 10'h004, 1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8,   32'hA000_0002, 10'h004, 1'b0);
    vecs[9]  = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC,   32'hA000_0003, 10'h005, 1'b0);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10,  32'hA000_0004, 10'h006, 1'b0);
    vecs[11] = mk(1'b1, 1'b1, 1'b1, 32'h103, 1'b0, 32'h0, 32'h0,         10'h040, 1'b0);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 32'hA000_0040, 10'h041, 1'b0);
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h104, 32'hA000_0041, 10'h042, 1'b0);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   32'h0,         10'h042, 1'b0);
    vecs[15] = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   32'h0,         10'h042, 1'b0);
    vecs[16] = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   32'h0,         10'h042, 1'b0);
    vecs[17] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   32'h0,         10'h042, 1'b0);
    vecs[18] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h108, 32'hA000_0042, 10'h043, 1'b0);
    vecs[19] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10C, 32'hA000_0043, 10'h044, 1'b0);
    vecs[20] = mk(1'b1, 1'b1, 1'b1, 32'hFFC, 1'b0, 32'h0, 32'h0,         10'h3FF, 1'b0);
    vecs[21] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFC, 32'hA000_03FF, 10'h000, 1'b0);
`ifdef FETCH_BOUND_CHECK_EN
    vecs[22] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0,         10'h000, 1'b1);
    vecs[23] = mk(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0,         10'h000, 1'b1);
`else
    vecs[22] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1000, 32'hA000_0000, 10'h001, 1'b0);
    vecs[23] = mk(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,  32'h0,         10'h080, 1'b0);
`endif

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("reset valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("reset addr",  {22'd0, bus.rom_addr},   32'd0);
    chk("reset pc_o",  bus.pc_o,                32'd0);
    chk("reset inst_o", bus.inst_o,             32'd0);
    chk("reset fault", {31'd0, bus.fetch_fault}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].fe, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
      tick();
      chk($sformatf("v%0d valid", i), {31'd0, bus.inst_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("v%0d addr", i),  {22'd0, bus.rom_addr},   {22'd0, vecs[i].addr});
      chk($sformatf("v%0d fault", i), {31'd0, bus.fetch_fault}, {31'd0, vecs[i].fault});
      if (vecs[i].valid) begin
        chk($sformatf("v%0d pc", i),   bus.pc_o,   vecs[i].pc);
        chk($sformatf("v%0d inst", i), bus.inst_o, vecs[i].inst);
      end
    end

    // Queue two entries, then reset mid-stream.
    drive(1'b1, 1'b0, 1'b1, 32'h40);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
`ifndef FETCH_BOUND_CHECK_EN
    chk("queued valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("queued pc",    bus.pc_o,                32'h40);
    chk("queued addr",  {22'd0, bus.rom_addr},   32'h12);
`endif
    rst = 1'b1;
    tick();
    chk("midrst valid",  {31'd0, bus.inst_valid},  32'd0);
    chk("midrst addr",   {22'd0, bus.rom_addr},    32'd0);
    chk("midrst fault",  {31'd0, bus.fetch_fault}, 32'd0);
    chk("midrst pc_o",   bus.pc_o,                 32'd0);
    chk("midrst inst_o", bus.inst_o,               32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk("restart c1 valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    chk("restart c2 valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("restart c2 pc",    bus.pc_o,                32'd0);
    chk("restart c2 inst",  bus.inst_o,              32'hA000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer for the processor's instruction ROM. Holds the fetch PC, drives the ROM word address, captures the combinational ROM output into a small instruction FIFO, and presents {pc, instruction} to decode through a valid/ready handshake. Branch/jump redirects flush the FIFO and restart fetch. Sits between the instruction ROM and the decode stage.

## Interface

- `ROM_DEPTH`, 1024: ROM words. Power of two. `AW = $clog2(ROM_DEPTH)`.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: byte PC loaded at reset. Word-aligned.
- `FIFO_DEPTH`, 2: instruction FIFO entries. Power of two, ≥2.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, synchronous, active-high.
- `fetch_en  in  1`: fetch enable. Low means no new ROM reads.
- `rom_addr  out  AW`: ROM word address, `fetch_pc[AW+1:2]`.
- `rom_data  in  DATA_W`: ROM read data, valid in the same cycle as `rom_addr`.
- `inst_o  out  DATA_W`: FIFO head instruction.
- `pc_o  out  32`: byte PC of `inst_o`.
- `inst_valid  out  1`: FIFO not empty.
- `inst_ready  in  1`: decode accepts the head.
- `redirect  in  1`: flush and restart at `redirect_pc`.
- `redirect_pc  in  32`: target byte PC. Bits [1:0] are ignored and forced to 0.
- `fetch_fault  out  1`: out-of-range fetch. Exists only with `FETCH_BOUND_CHECK_EN`; otherwise tied 0.

## Operation

- FSM states: IDLE, RUN, FAULT. FAULT is reachable only with the macro.
- IDLE → RUN when `fetch_en`=1. RUN → IDLE when `fetch_en`=0. FAULT exits only through `rst`.
- Push: in RUN, when `count < FIFO_DEPTH`, or when `count == FIFO_DEPTH` and a pop happens in the same cycle.
  - On push, write {fetch_pc, rom_data} to the FIFO and set `fetch_pc += 4`.
  - Without a push, `fetch_pc` holds.
- Pop: `inst_valid && inst_ready`. Simultaneous push and pop leaves `count` unchanged.
- Redirect priority: `redirect` overrides push and pop.
  - FIFO is cleared (`count`=0).
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - A pop in the same cycle is discarded. Decode must not consume that head.
  - A redirect in IDLE also updates `fetch_pc`. FSM state is unchanged.
  - A redirect in FAULT is ignored.
- Wrap-around:
  - `fetch_pc` is a 32-bit modular counter.
  - `rom_addr` uses the low bits, so fetch wraps modulo ROM_DEPTH words when the bound check is off.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by `count`, not by pointer equality.

## Timing

- Reset values:
  - State IDLE, `fetch_pc = RESET_PC`, `count` = 0.
  - `inst_valid` = 0, `fetch_fault` = 0.
  - `rom_addr = RESET_PC[AW+1:2]`.
  - `inst_o` and `pc_o` = 0. FIFO storage is reset to zero.
- Latency:
  - With `fetch_en` high from reset release, cycle 0 is IDLE, cycle 1 is RUN and pushes, and `inst_valid` rises in cycle 2.
  - After redirect at edge N, the target is read in cycle N+1 and `inst_valid` rises in cycle N+2. The redirect penalty is 2 cycles.
- Sustained throughput is 1 instruction/cycle while `inst_ready`=1.
- Outputs `inst_o`, `pc_o`, and `inst_valid` come from registers and FIFO storage only. There is no combinational path from `rom_data` or `inst_ready`.
- `rst` mid-stream: all state returns to reset values on that edge. Any in-flight FIFO contents are lost.

## Configuration

- Macro `FETCH_BOUND_CHECK_EN`.
- **Defined:**
  - In RUN, if `fetch_pc[31:AW+2] != 0`, no push occurs and the FSM enters FAULT.
  - `fetch_fault` is registered and goes high the next cycle.
  - FIFO contents already stored still drain normally.
- **Undefined:**
  - No check. Address wraps modulo ROM_DEPTH.
  - `fetch_fault` is constant 0 and FAULT is not synthesised.

## Structure

- Package `fetch_pkg`:
  - typedef `fetch_state_t` {IDLE, RUN, FAULT}.
  - struct `fetch_entry_t` {logic [31:0] pc; logic [DATA_W-1:0] inst}.
  - `PC_STEP` = 4.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with push, pop, clear (clear has priority), count, full, and empty. `imem_fetch_ctrl` holds the FSM, the PC, and the push/pop/redirect logic.

## Test plan

- **Reset and sequential fetch:** ROM word k = 32'hA000_0000+k, `fetch_en`=1, `inst_ready`=1. Expected: first valid in cycle 2 with pc 0 / A0000000, then pc 4, 8, … on consecutive cycles.
- **Backpressure:** `inst_ready`=0 for 5 cycles. Expected: FIFO fills to 2 and `rom_addr` holds; on release the entries drain in order with no loss or duplication.
- **Redirect:** assert with `redirect_pc`=32'h0000_0103 while the FIFO is full and `inst_ready`=1. Expected: FIFO flushed, next valid pc = 0x100 two cycles later, and the discarded head is never re-presented.
- **`fetch_en` toggle:** drop `fetch_en` for 3 cycles. Expected: no pushes, PC holds; fetch resumes at the same PC when `fetch_en` returns high.
- **Wrap:** set `redirect_pc` = 4·(ROM_DEPTH−1). Expected without the macro: next PCs 0xFFC, 0x1000 with `rom_addr` 1023, 0. Expected with `FETCH_BOUND_CHECK_EN`: 0x1000 not pushed, `fetch_fault`=1, redirect ignored.
- **Reset mid-stream:** pulse `rst` with 2 entries queued. Expected: next cycle `inst_valid`=0 and `fetch_pc`=RESET_PC.
